// File: rtl/mips_pkg.sv
// Shared fetch-path types and constants for the single-cycle MIPS core.
// Imported by the fetch controller and its prefetch queue.
package mips_pkg;

  localparam logic [31:0] OPCODE_NOP_HALT  = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous prefetch FIFO of fetch_entry_t; the head is read straight
// from registered storage and forced to zero while the queue is empty.
module fetch_queue
  import mips_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  fetch_entry_t  mem_reg [DEPTH];
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [AW:0]   count_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  // Flush wins over push/pop: a redirect discards everything still queued.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign empty = (count_reg == '0);
  assign full  = (count_reg == FULL_CNT);
  assign count = count_reg;
  assign head  = empty ? '0 : mem_reg[rd_ptr_reg];

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fills the prefetch queue from
// the combinational instruction memory and halts on an all-zero word.
module fetch_ctrl
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        halted
);

  localparam int AW = $clog2(DEPTH);

  fetch_state_t state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic         q_push, q_pop, q_full, q_empty;
  logic         fetch_en;
  logic [AW:0]  count_unused;
  fetch_entry_t head, push_entry;

  assign q_pop    = instr_valid & instr_ready;
  assign fetch_en = (state_reg == ST_RUN) & ~redirect_valid & (~q_full | q_pop);
  assign q_push   = fetch_en & (imem_data != OPCODE_NOP_HALT);

  assign push_entry.instr = imem_data;
  assign push_entry.pc    = pc_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_RUN;
      pc_reg    <= RESET_PC;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    if (redirect_valid) begin
      state_next = ST_RUN;
      pc_next    = {redirect_pc[31:2], 2'b00};
    end else if (fetch_en) begin
      // A zero word marks unmapped memory: stop fetching and hold the PC.
      if (imem_data == OPCODE_NOP_HALT) begin
        state_next = ST_HALT;
      end else begin
        pc_next = pc_reg + PC_STEP;
      end
    end
  end

  fetch_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk      (clk),
    .reset    (reset),
    .push     (q_push),
    .push_data(push_entry),
    .pop      (q_pop),
    .flush    (redirect_valid),
    .head     (head),
    .full     (q_full),
    .empty    (q_empty),
    .count    (count_unused)
  );

  assign imem_addr   = pc_reg;
  assign instr_valid = ~q_empty;
  assign instr       = head.instr;
  assign instr_pc    = head.pc;
  assign halted      = (state_reg == ST_HALT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus random traffic
// compared cycle by cycle against a queue-based reference model.
module tb_fetch_ctrl;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        halted;

  always #5 clk = ~clk;

  fetch_ctrl #(
    .RESET_PC(RPC),
    .DEPTH   (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready),
    .halted        (halted)
  );

  // Instruction memory: table for 0x00-0xFC, nonzero pattern elsewhere.
  logic [31:0] mem [64];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'h100) return mem[a[7:2]];
    return a | 32'h1;
  endfunction

  always_comb imem_data = mem_word(imem_addr);

  // Reference model: a plain list of fetched words plus the next fetch address.
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pc;
  logic        m_halt;

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input logic rst, input logic rv, input logic [31:0] rpc,
                            input logic rdy);
    logic        do_pop, do_fetch;
    logic [31:0] w;
    ent_t        e;
    if (rst) begin
      m_q.delete();
      m_pc   = RPC;
      m_halt = 1'b0;
      return;
    end
    do_pop   = (m_q.size() > 0) && rdy;
    do_fetch = !m_halt && !rv && ((m_q.size() < DEPTH) || do_pop);
    w        = mem_word(m_pc);
    if (do_pop) void'(m_q.pop_front());
    if (rv) begin
      m_q.delete();
      m_pc   = rpc & 32'hFFFF_FFFC;
      m_halt = 1'b0;
    end else if (do_fetch) begin
      if (w != 32'h0) begin
        e.instr = w;
        e.pc    = m_pc;
        m_q.push_back(e);
        m_pc = m_pc + 32'd4;
      end else begin
        m_halt = 1'b1;
      end
    end
  endtask

  // Called just after a falling edge: check outputs, drive inputs, advance.
  task automatic cycle(input logic rst, input logic rv, input logic [31:0] rpc,
                       input logic rdy);
    chk("imem_addr", imem_addr, m_pc);
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, (m_q.size() != 0)});
    chk("halted", {31'b0, halted}, {31'b0, m_halt});
    if (m_q.size() != 0) begin
      chk("instr", instr, m_q[0].instr);
      chk("instr_pc", instr_pc, m_q[0].pc);
    end
    reset          = rst;
    redirect_valid = rv;
    redirect_pc    = rpc;
    instr_ready    = rdy;
    model_step(rst, rv, rpc, rdy);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic        r_rst, r_rv, r_rdy;
    logic [31:0] r_pc;

    mem[0] = 32'h2008_0001;  // addi
    mem[1] = 32'h2009_0002;
    mem[2] = 32'h1109_0003;  // beq
    mem[3] = 32'h2108_0001;
    mem[4] = 32'h1109_0001;
    mem[5] = 32'h2129_0004;
    mem[6] = 32'h1108_fffe;
    mem[7] = 32'h2108_0010;
    mem[8] = 32'h200a_0005;
    mem[9] = 32'h0000_0000;
    for (int i = 10; i < 64; i++)
      mem[i] = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom | 32'h1);

    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
    m_pc = RPC; m_halt = 1'b0;
    @(negedge clk);

    // 1: straight-line program runs to the zero word and halts
    cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 1);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_imem_addr", imem_addr, RPC);
    for (int i = 0; i < 14; i++) cycle(0, 0, 0, 1);
    chk("t1_halted", {31'b0, halted}, 32'd1);
    chk("t1_addr", imem_addr, 32'h24);
    chk("t1_valid", {31'b0, instr_valid}, 32'd0);

    // 2: stalled decode fills the queue, then pop and fetch overlap
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);
    chk("t2_addr_stuck", imem_addr, 32'h08);
    chk("t2_head", instr_pc, 32'h00);
    cycle(0, 0, 0, 1);
    chk("t2_head_after", instr_pc, 32'h04);
    chk("t2_addr_after", imem_addr, 32'h0C);

    // 3: redirect together with the pop of the beq at 0x08
    cycle(0, 0, 0, 1);
    chk("t3_head_beq", instr_pc, 32'h08);
    cycle(0, 1, 32'h21, 1);
    chk("t3_addr", imem_addr, 32'h20);
    chk("t3_flushed", {31'b0, instr_valid}, 32'd0);
    cycle(0, 0, 0, 0);
    chk("t3_target_valid", {31'b0, instr_valid}, 32'd1);
    chk("t3_target_pc", instr_pc, 32'h20);

    // 4: redirect out of HALT
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1);
    chk("t4_halted", {31'b0, halted}, 32'd1);
    cycle(0, 1, 32'h04, 1);
    chk("t4_unhalted", {31'b0, halted}, 32'd0);
    chk("t4_addr", imem_addr, 32'h04);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    chk("t4_resume", instr_pc, 32'h08);

    // 5: PC wraps past the top of the address space
    cycle(0, 1, 32'hFFFF_FFFC, 1);
    chk("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
    cycle(0, 0, 0, 1);
    chk("t5_wrap", imem_addr, 32'h0);
    chk("t5_head_pc", instr_pc, 32'hFFFF_FFFC);

    // 6: reset beats a simultaneous redirect
    cycle(0, 0, 0, 1);
    cycle(1, 1, 32'h40, 1);
    chk("t6_valid", {31'b0, instr_valid}, 32'd0);
    chk("t6_addr", imem_addr, RPC);
    chk("t6_halted", {31'b0, halted}, 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      r_rst = ($urandom_range(0, 99) == 0);
      r_rv  = ($urandom_range(0, 19) == 0);
      r_rdy = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 9) == 0) r_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      else                           r_pc = $urandom & 32'hFF;
      cycle(r_rst, r_rv, r_pc, r_rdy);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer for the single-cycle MIPS core. Owns the program counter and drives the address of the combinational instruction memory. Captures returned words into a small prefetch queue and presents them to decode with a valid/ready handshake. Branch/jump redirects flush the queue. An all-zero word, which the instruction memory returns for unmapped addresses, halts fetch.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset
DEPTH, 2, prefetch queue entries (power of two, ≥2)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
imem_addr  out  32  instruction memory address; equals pc register
imem_data  in  32  instruction word, combinational from imem_addr in the same cycle
redirect_valid  in  1  branch/jump taken this cycle
redirect_pc  in  32  target address; bits [1:0] ignored, treated as 0
instr_valid  out  1  queue head valid
instr  out  32  queue head instruction word
instr_pc  out  32  address the head word was fetched from
instr_ready  in  1  decode accepts head this cycle
halted  out  1  fetch stopped on zero word

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset, sampled on the clk edge: pc=RESET_PC, queue empty, state=RUN. Outputs after reset: instr_valid=0, halted=0, imem_addr=RESET_PC. instr and instr_pc are don't-care while instr_valid=0; drive them to 0 after reset.
- States: RUN and HALT. halted=1 only in HALT.
- pop = instr_valid & instr_ready.
- fetch_en = (state==RUN) & !redirect_valid & (count<DEPTH | pop).
- When fetch_en is set and imem_data != 0:
  - push {imem_data, pc} at the queue tail.
  - pc <= pc+4, wrapping modulo 2^32 (0xFFFFFFFC -> 0x0).
- When fetch_en is set and imem_data == 0:
  - do not push; pc holds.
  - state <= HALT.
- Latency: a word fetched in cycle N is visible at instr/instr_valid in cycle N+1. It is not bypassed combinationally to the outputs.
- Full (count==DEPTH) and no pop: no fetch; pc holds.
- Full with pop in the same cycle: fetch proceeds. Simultaneous push and pop leave count unchanged.
- Empty: instr_valid=0; a pop cannot occur.
- Redirect (redirect_valid=1):
  - A handshake in the same cycle completes first: the head is consumed.
  - All remaining entries are flushed (count<=0).
  - pc <= {redirect_pc[31:2],2'b00}; state <= RUN, which also clears HALT.
  - No fetch in the redirect cycle. The first fetch from the target happens the next cycle, and its word is valid one cycle after that.
- HALT: pc frozen; no fetches. Already-queued words keep draining through the handshake. Leave HALT only on redirect or reset.
- Reset asserted mid-operation overrides everything, including a redirect or handshake in the same cycle.
- Outputs instr, instr_pc and instr_valid come from registered queue storage. imem_addr comes from the pc register, so there is no combinational path from instr_ready to imem_addr.
- Queue: circular buffer with rd/wr pointers of log2(DEPTH) bits and a count of log2(DEPTH)+1 bits.

Decomposition:
- Shared package (mips_pkg):
  - OPCODE_NOP_HALT = 32'h0
  - PC_STEP = 4
  - RESET_PC default
  - struct fetch_entry_t {instr[31:0], pc[31:0]}
- One sub-module: fetch_queue, a synchronous DEPTH-entry FIFO of fetch_entry_t with push, pop, flush, full, empty and count.
- The PC register and the RUN/HALT state machine stay in fetch_ctrl.

Test Plan:
1. Reset, then instr_ready=1 held, memory holding the 9-word program at 0x00–0x20 (addi at 0x00, alternating addi/beq through 0x1C, addi at 0x20): instr_pc sequence 0x00,0x04,…,0x20, one per cycle from cycle 1 after reset. The fetch at 0x24 returns 0 -> halted=1, and instr_valid drops after 0x20 is popped.
2. instr_ready=0 after reset: queue fills to 2 (0x00, 0x04); imem_addr sticks at 0x08. Raise ready: 0x00 pops while 0x08 is fetched in the same cycle; count stays 2.
3. Pop of 0x08 (beq) with redirect_valid=1, redirect_pc=0x00000021 in the same cycle: the pop completes, queued 0x0C is flushed, imem_addr=0x20 next cycle, and instr_pc=0x20 valid the cycle after.
4. In HALT at pc=0x24, redirect to 0x04: halted=0 next cycle and fetch resumes at 0x04, 0x08, …
5. Redirect to 0xFFFFFFFC with memory returning nonzero there: the next fetch address wraps to 0x00000000.
6. reset asserted mid-stream together with redirect_valid=1: queue empty, instr_valid=0, imem_addr=RESET_PC on the next cycle; the redirect is ignored.
